instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 16, meaning the program-memory byte address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the ROM word (opcode byte) width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the prefetch FIFO entries (power of two, at least 2).
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port rom_addr, output, ADDRESS_WIDTH, the address presented to the program ROM.
REQ-007 The block SHALL have port rom_data, input, DATA_WIDTH, the ROM registered output, valid one cycle after rom_addr is sampled.
REQ-008 The block SHALL have port jump, input, 1, a one-cycle pulse requesting a PC redirect.
REQ-009 The block SHALL have port jump_addr, input, ADDRESS_WIDTH, the redirect target, sampled when jump=1.
REQ-010 The block SHALL have port instr_valid, output, 1, meaning the FIFO head byte is available to the decoder.
REQ-011 The block SHALL have port instr_ready, input, 1, meaning the decoder accepts the head byte this cycle.
REQ-012 The block SHALL have port instr_byte, output, DATA_WIDTH, the FIFO head byte.
REQ-013 The block SHALL have port instr_pc, output, ADDRESS_WIDTH, the ROM address instr_byte was fetched from.

Function
REQ-014 rom_addr SHALL equal the registered fetch_pc at all times; no combinational path from jump_addr to rom_addr.
REQ-015 A request SHALL be issued in a cycle iff jump=0 and (fifo_count + inflight) < DEPTH, where inflight is 1 when a request was issued in the previous cycle.
REQ-016 On issue, fetch_pc SHALL increment by 1 modulo 2^ADDRESS_WIDTH (0xFFFF wraps to 0x0000); otherwise fetch_pc SHALL hold.
REQ-017 The block SHALL register the issued address as inflight_pc; in the next cycle, if inflight=1 and jump=0, rom_data and inflight_pc SHALL be pushed into the FIFO.
REQ-018 A pop SHALL occur iff instr_valid=1 and instr_ready=1.
REQ-019 instr_valid SHALL be (fifo_count != 0) AND NOT jump; a jump cycle never completes a handshake.
REQ-020 instr_byte and instr_pc SHALL be driven from the FIFO head and SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-021 A simultaneous push and pop SHALL leave fifo_count unchanged, with FIFO order preserved.
REQ-022 With instr_ready held at 1 and no jumps, throughput SHALL be one byte per cycle sustained.
REQ-023 When jump=1, the block SHALL clear fifo_count to 0, set inflight to 0, discard the returning rom_data, and load fetch_pc with jump_addr.
REQ-024 After a jump in cycle J, rom_addr SHALL equal jump_addr in J+1, and the first new byte SHALL be valid in J+3 with instr_pc=jump_addr.
REQ-025 Back-to-back jumps SHALL let the last one win.
REQ-026 fifo_count SHALL never exceed DEPTH, and no push SHALL occur when the FIFO is full, which REQ-015 guarantees.

Reset
REQ-027 While reset=1, the block SHALL set fetch_pc=0x0000, fifo_count=0, inflight=0, instr_valid=0, instr_byte=0x00, instr_pc=0x0000, and issue no request.
REQ-028 reset SHALL override jump and any handshake in the same cycle.
REQ-029 Asserting reset mid-stream SHALL discard all buffered and in-flight bytes.
REQ-030 After reset, the first cycle with reset=0 (R) SHALL issue address 0x0000, and instr_valid SHALL rise in R+2 with instr_pc=0x0000.

Verification
REQ-031 Reset release test: with ROM[0..3]=02,00,10,E4 and ready=1, the bench SHALL see bytes 02,00,10,E4 on cycles R+2..R+5 with instr_pc 0..3.
REQ-032 Backpressure test: with ready=0 from R, the bench SHALL see at most 4 issues, fetch_pc stopping at 0x0004 and count=4; after ready=1 for 1 cycle, one pop then exactly one new issue at 0x0004.
REQ-033 Jump test: with jump=1 and jump_addr=0x0100 at cycle J while count=3, the bench SHALL see instr_valid=0 at J, J+1, J+2, rom_addr=0x0100 at J+1, and instr_pc=0x0100 valid at J+3.
REQ-034 Wrap test: with a jump to 0xFFFE and ready=1, the bench SHALL see instr_pc sequence FFFE, FFFF, 0000, 0001.
REQ-035 Mid-operation reset test: with reset asserted while count=2 and a request in flight, the bench SHALL see instr_valid=0 the next cycle and restart from 0x0000 per REQ-030.
REQ-036 Random test: with random ready and jump, a scoreboard SHALL verify every accepted byte equals ROM[instr_pc] and consecutive pcs increment by 1 except across jumps.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction prefetch unit: streams opcode bytes from a registered-output program ROM
// into a small FIFO with a valid/ready handshake toward the decoder, with PC redirect.
module instruction_fetch #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  input  logic                     jump,
  input  logic [ADDRESS_WIDTH-1:0] jump_addr,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr_byte,
  output logic [ADDRESS_WIDTH-1:0] instr_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                     inflight_q, inflight_d;
  logic [CW-1:0]            count_q, count_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0]    byte_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]    byte_mem_d [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem_d [DEPTH];

  logic issue, push, pop;

  // Credit check counts the in-flight request so the returning byte always has a slot.
  assign issue = !reset && !jump && ((count_q + CW'(inflight_q)) < CW'(DEPTH));
  assign push  = !reset && !jump && inflight_q;
  assign pop   = instr_valid && instr_ready;

  assign rom_addr    = fetch_pc_q;
  assign instr_valid = !reset && !jump && (count_q != '0);
  assign instr_byte  = reset ? '0 : byte_mem_q[rd_ptr_q];
  assign instr_pc    = reset ? '0 : pc_mem_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = inflight_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    byte_mem_d    = byte_mem_q;
    pc_mem_d      = pc_mem_q;
    if (jump) begin
      // Redirect flushes everything, including the byte returning this cycle.
      fetch_pc_d = jump_addr;
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) begin
        byte_mem_d[wr_ptr_q] = rom_data;
        pc_mem_d[wr_ptr_q]   = inflight_pc_q;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + ADDRESS_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= '0;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        byte_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      byte_mem_q    <= byte_mem_d;
      pc_mem_q      <= pc_mem_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized ready/jump/reset traffic,
// checked against a queue-based reference model and an accepted-byte scoreboard.
module tb_instruction_fetch;
  localparam int AW = 16, DW = 8, DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset, jump, instr_ready;
  logic [AW-1:0] jump_addr;
  logic [AW-1:0] rom_addr, instr_pc;
  logic [DW-1:0] rom_data, instr_byte;
  logic          instr_valid;

  instruction_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .jump(jump), .jump_addr(jump_addr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_byte(instr_byte), .instr_pc(instr_pc));

  always #5 clock = ~clock;

  logic [DW-1:0] rom [0:65535];
  always @(posedge clock) rom_data <= rom[rom_addr];

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of fetched pcs (byte = rom[pc]), one outstanding request.
  int mq[$];
  bit m_inf, m_init;
  int m_ipc, m_fpc;
  // Scoreboard over accepted bytes.
  bit sb_have;
  int sb_last;
  // Outputs observed during the last cycle.
  logic          obs_valid;
  logic [DW-1:0] obs_byte;
  logic [AW-1:0] obs_pc, obs_addr;

  task automatic cyc(input bit rst, input bit jmp, input logic [AW-1:0] ja, input bit rdy);
    bit mv, iss;
    reset = rst; jump = jmp; jump_addr = ja; instr_ready = rdy;
    #1;
    obs_valid = instr_valid; obs_byte = instr_byte; obs_pc = instr_pc; obs_addr = rom_addr;
    mv = !rst && !jmp && (mq.size() != 0);
    if (m_init || rst) begin
      check("m_valid", obs_valid, mv);
      if (rst) begin
        check("rst_byte", obs_byte, 0);
        check("rst_pc", obs_pc, 0);
      end else if (mv) begin
        check("m_pc", obs_pc, mq[0]);
        check("m_byte", obs_byte, rom[mq[0]]);
      end
    end
    if (m_init) check("m_rom_addr", obs_addr, m_fpc);
    if (!rst && obs_valid && rdy) begin
      check("sb_byte", obs_byte, rom[obs_pc]);
      if (sb_have) check("sb_seq", obs_pc, (sb_last + 1) & 32'hFFFF);
      sb_have = 1; sb_last = obs_pc;
    end
    if (rst || jmp) sb_have = 0;
    @(posedge clock);
    if (rst) begin
      mq.delete(); m_inf = 0; m_fpc = 0; m_init = 1;
    end else if (jmp) begin
      mq.delete(); m_inf = 0; m_fpc = ja;
    end else begin
      iss = (mq.size() + int'(m_inf)) < DEPTH;
      if (mv && rdy) void'(mq.pop_front());
      if (m_inf) mq.push_back(m_ipc);
      m_inf = iss;
      if (iss) begin
        m_ipc = m_fpc;
        m_fpc = (m_fpc + 1) & 32'hFFFF;
      end
    end
    #1;
  endtask

  initial begin
    logic [DW-1:0] e31 [4];
    int wpcs[$];
    bit rr, jj, rd;
    logic [AW-1:0] ja;
    e31 = '{8'h02, 8'h00, 8'h10, 8'hE4};
    for (int i = 0; i < 65536; i++) rom[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) rom[i] = e31[i];
    reset = 1; jump = 0; jump_addr = 0; instr_ready = 0;
    m_init = 0; m_inf = 0; sb_have = 0;
    @(posedge clock); #1;

    // Reset state, then release with ready held high.
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    check("rst_valid", obs_valid, 0);
    check("rst_rom_addr", obs_addr, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1);
      if (i < 2) check("rel_valid_lo", obs_valid, 0);
      else begin
        check("rel_valid", obs_valid, 1);
        check("rel_byte", obs_byte, e31[i-2]);
        check("rel_pc", obs_pc, i - 2);
      end
    end

    // Backpressure: four issues, then one pop frees exactly one slot.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
    check("bp_stall_addr", obs_addr, 4);
    cyc(0, 0, 0, 1);
    check("bp_pop_pc", obs_pc, 0);
    cyc(0, 0, 0, 0);
    check("bp_next_pc", obs_pc, 1);
    check("bp_issue_addr", obs_addr, 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    check("bp_one_issue", obs_addr, 5);

    // Jump while three bytes are buffered.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 16'h0100, 0);
    check("jmp_valid_j", obs_valid, 0);
    cyc(0, 0, 0, 0);
    check("jmp_valid_j1", obs_valid, 0);
    check("jmp_rom_addr", obs_addr, 16'h0100);
    cyc(0, 0, 0, 0);
    check("jmp_valid_j2", obs_valid, 0);
    cyc(0, 0, 0, 1);
    check("jmp_valid_j3", obs_valid, 1);
    check("jmp_pc_j3", obs_pc, 16'h0100);

    // Address wrap through 0xFFFF.
    cyc(0, 1, 16'hFFFE, 1);
    for (int i = 0; i < 12 && wpcs.size() < 4; i++) begin
      cyc(0, 0, 0, 1);
      if (obs_valid) wpcs.push_back(obs_pc);
    end
    check("wrap_count", wpcs.size(), 4);
    for (int i = 0; i < wpcs.size() && i < 4; i++)
      check("wrap_pc", wpcs[i], (16'hFFFE + i) & 16'hFFFF);

    // Reset mid-stream with two bytes buffered and one in flight.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("mrst_valid_r", obs_valid, 0);
    check("mrst_addr_r", obs_addr, 0);
    cyc(0, 0, 0, 1);
    check("mrst_valid_r1", obs_valid, 0);
    cyc(0, 0, 0, 1);
    check("mrst_valid_r2", obs_valid, 1);
    check("mrst_pc_r2", obs_pc, 0);

    // Random ready / jump / occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 499) == 0);
      jj = ($urandom_range(0, 15) == 0);
      rd = ($urandom_range(0, 2) != 0);
      ja = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFC + $urandom_range(0, 3)) : AW'($urandom);
      cyc(rr, jj, ja, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
